// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit holding the architectural HI/LO registers
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  Op,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;
    logic          pend_valid;

    logic [63:0]   res;
    logic          res_valid;
    logic signed [31:0] sq;
    logic signed [31:0] sr;

    always_comb begin
        res       = 64'd0;
        res_valid = 1'b1;
        sq        = 32'sd0;
        sr        = 32'sd0;
        case (Op)
            3'd1: res = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
            3'd2: res = {32'd0, A} * {32'd0, B};
            3'd3: begin
                if (B == 32'd0) begin
                    res_valid = 1'b0;
                end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                    // Quotient overflows 32 bits; wraps back to the dividend with zero remainder.
                    res = {32'd0, 32'h8000_0000};
                end else begin
                    sq  = $signed(A) / $signed(B);
                    sr  = $signed(A) % $signed(B);
                    res = {sr, sq};
                end
            end
            3'd4: begin
                if (B == 32'd0) begin
                    res_valid = 1'b0;
                end else begin
                    res = {A % B, A / B};
                end
            end
            default: res_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            Busy       <= 1'b0;
            count      <= '0;
            HI         <= 32'd0;
            LO         <= 32'd0;
            pend_hi    <= 32'd0;
            pend_lo    <= 32'd0;
            pend_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (Op)
                            3'd1, 3'd2, 3'd3, 3'd4: begin
                                pend_hi    <= res[63:32];
                                pend_lo    <= res[31:0];
                                pend_valid <= res_valid;
                                count      <= (Op == 3'd1 || Op == 3'd2) ? CW'(MULT_CYCLES)
                                                                         : CW'(DIV_CYCLES);
                                state      <= BUSY;
                                Busy       <= 1'b1;
                            end
                            3'd5: HI <= A;
                            3'd6: LO <= A;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    // Last busy cycle: commit (unless it was a divide by zero) and release.
                    if (count == CW'(1)) begin
                        if (pend_valid) begin
                            HI <= pend_hi;
                            LO <= pend_lo;
                        end
                        count <= '0;
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - self-checking bench for mdu: vector table, random ops vs model, corner sequences
module tb_mdu;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [2:0]  Op;
    logic        Start;
    logic        Busy;
    logic [31:0] HI, LO;

    int total = 0;
    int bad = 0;

    logic [31:0] m_hi, m_lo;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .Op(Op),
        .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour: plain 64-bit arithmetic on the architectural registers.
    function automatic int model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, q, r;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; return MC; end
            3'd2: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; return MC; end
            3'd3: begin
                if (b != 0) begin q = sa / sb; r = sa % sb; m_hi = r[31:0]; m_lo = q[31:0]; end
                return DC;
            end
            3'd4: begin
                if (b != 0) begin up = ua / ub; m_lo = up[31:0]; up = ua % ub; m_hi = up[31:0]; end
                return DC;
            end
            3'd5: begin m_hi = a; return 0; end
            3'd6: begin m_lo = a; return 0; end
            default: return 0;
        endcase
    endfunction

    // Issue one op, count Busy cycles at negedges, check HI/LO are frozen then committed.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int ecyc);
        int n;
        logic [31:0] old_hi, old_lo;
        logic frozen;
        old_hi = HI;
        old_lo = LO;
        frozen = 1'b1;
        @(negedge clk);
        Op = op; A = a; B = b; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; Op = 3'd0;
        n = 0;
        while (Busy && n < 40) begin
            if (HI !== old_hi || LO !== old_lo) frozen = 1'b0;
            n++;
            @(negedge clk);
        end
        chk({name, " busy_cycles"}, 64'(n), 64'(ecyc));
        if (ecyc > 0) chk({name, " frozen"}, 64'(frozen), 64'd1);
        chk({name, " hilo"}, {HI, LO}, {ehi, elo});
    endtask

    initial begin
        vec_t vt[13];
        int   ec;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int   n;
        logic stayed;

        vt[0]  = '{3'd1, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, MC};
        vt[1]  = '{3'd2, 32'hFFFF_FFFF, 32'h2,         32'h1,         32'hFFFF_FFFE, MC};
        vt[2]  = '{3'd3, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
        vt[3]  = '{3'd5, 32'h11,        32'h0,         32'h11,        32'hFFFF_FFFD, 0};
        vt[4]  = '{3'd6, 32'h22,        32'h0,         32'h11,        32'h22,        0};
        vt[5]  = '{3'd4, 32'h7,         32'h0,         32'h11,        32'h22,        DC};
        vt[6]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, DC};
        vt[7]  = '{3'd0, 32'h5,         32'h6,         32'h0,         32'h8000_0000, 0};
        vt[8]  = '{3'd7, 32'h5,         32'h6,         32'h0,         32'h8000_0000, 0};
        vt[9]  = '{3'd4, 32'd100,       32'd7,         32'h2,         32'hE,         DC};
        vt[10] = '{3'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0,         32'hC,         MC};
        vt[11] = '{3'd3, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, DC};
        vt[12] = '{3'd3, 32'h5,         32'h0,         32'h1,         32'hFFFF_FFFD, DC};

        reset = 1'b1; Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_state", {31'd0, Busy, HI, LO}, 64'd0);
        reset = 1'b0;

        foreach (vt[i])
            do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].cycles);

        m_hi = HI_EXP_SEED(vt[12].hi);
        m_lo = vt[12].lo;
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            ec  = model_op(rop, ra, rb);
            do_op($sformatf("rnd%0d", i), rop, ra, rb, m_hi, m_lo, ec);
        end

        // Start of mtlo during multiply busy must be ignored.
        @(negedge clk);
        Op = 3'd1; A = 32'd3; B = 32'd4; Start = 1'b1;
        @(negedge clk);
        Op = 3'd6; A = 32'h5;
        @(negedge clk);
        Start = 1'b0; Op = 3'd0;
        n = 2;
        while (Busy && n < 40) begin n++; @(negedge clk); end
        chk("mtlo_in_busy cycles", 64'(n), 64'(MC + 1));
        chk("mtlo_in_busy hilo", {HI, LO}, {32'd0, 32'd12});

        // Reset in the middle of a divide discards the pending result.
        @(negedge clk);
        Op = 3'd4; A = 32'd50; B = 32'd3; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; Op = 3'd0;
        repeat (3) @(negedge clk);
        chk("div_pre_reset busy", 64'(Busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_reset state", {31'd0, Busy, HI, LO}, 64'd0);
        stayed = 1'b1;
        repeat (DC + 3) begin
            @(negedge clk);
            if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) stayed = 1'b0;
        end
        chk("no_late_commit", 64'(stayed), 64'd1);

        // Reset beats a same-cycle mthi.
        @(negedge clk);
        Op = 3'd5; A = 32'h99; Start = 1'b1; reset = 1'b1;
        @(negedge clk);
        Start = 1'b0; Op = 3'd0; reset = 1'b0;
        chk("reset_priority", {31'd0, Busy, HI, LO}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic [31:0] HI_EXP_SEED(input logic [31:0] v);
        return v;
    endfunction
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameters: MULT_CYCLES, 5, busy cycles for mult/multu.
REQ-002 Parameters: DIV_CYCLES, 10, busy cycles for div/divu.
REQ-003 Ports: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Ports: reset  in  1  synchronous, active-high.
REQ-005 Ports: A  in  32  operand rs (dividend / multiplicand / mthi-mtlo data).
REQ-006 Ports: B  in  32  operand rt (divisor / multiplier).
REQ-007 Ports: Op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-008 Ports: Start  in  1  qualifies Op for one cycle; issued by the EX stage.
REQ-009 Ports: Busy  out  1  high while a mult/div is in flight.
REQ-010 Ports: HI  out  32  architectural HI register.
REQ-011 Ports: LO  out  32  architectural LO register.
REQ-012 Ports: clk and reset named exactly as in the rest of the core; reset is synchronous and active-high.

Function
REQ-013 The block SHALL hold two states: IDLE and BUSY, plus a down-counter wide enough for DIV_CYCLES.
REQ-014 In IDLE, Start=1 with Op 1-4 at edge k SHALL latch the computed 64-bit result into internal pending registers, load the counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY.
REQ-015 Busy SHALL be 1 for exactly N cycles following edge k (N = configured cycles); HI/LO SHALL update and Busy SHALL fall at edge k+N.
REQ-016 HI/LO SHALL NOT change while BUSY; outputs are the old values until commit.
REQ-017 mult: {HI,LO} = signed A * signed B, 64-bit; multu: unsigned product.
REQ-018 div: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-019 div with A=0x80000000, B=0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-020 Division by zero SHALL still occupy DIV_CYCLES of Busy and SHALL leave HI and LO unchanged at commit.
REQ-021 In IDLE, Start=1 with Op 5 SHALL write HI=A at that edge (Op 6: LO=A); Busy stays 0.
REQ-022 Start with Op 0 or 7 SHALL have no effect.
REQ-023 Start (any Op) while BUSY SHALL be ignored; operands are not re-sampled; the pipeline stalls on Busy to prevent this.
REQ-024 Busy SHALL be driven from a register, never combinationally from Start.
REQ-025 Stall requirement on the pipeline: an md-class instruction in ID SHALL stall while Busy=1 or while Start=1 for Op 1-4; the block itself does not generate stalls.

Reset
REQ-026 reset=1 at an edge SHALL set HI=0, LO=0, Busy=0, counter=0, state IDLE, discarding any pending result, including mid-operation.
REQ-027 reset SHALL take priority over Start in the same cycle.

Verification
REQ-028 mult A=0xFFFFFFFF, B=0x00000002, Start one cycle -> Busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE, Busy=0.
REQ-029 multu A=0xFFFFFFFF, B=0x00000002 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-030 div A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 after mthi/mtlo of 0x11/0x22 -> HI=0x11, LO=0x22 after 10 cycles.
REQ-031 Start mult, then Start mtlo A=0x5 on cycle 2 of Busy -> mtlo ignored, LO equals the product at commit.
REQ-032 Start div, assert reset on cycle 4 of Busy -> next cycle Busy=0, HI=LO=0; no later commit.
